// File: rtl/conv_window_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_scheduler
// Purpose  : Slides a Filter_rows x Filter_Cols window over the image in
//            raster order, one single_convolution run per position.
//            Optional watchdog: define CONV_SCHED_WDOG_EN.
// Revision : 1.0
// ============================================================================
module conv_window_scheduler #(
  parameter int addressBitWidth = 16,
  parameter int Img_rows        = 4,
  parameter int Img_cols        = 8,
  parameter int Filter_rows     = 2,
  parameter int Filter_Cols     = 5,
  parameter int STRIDE          = 1
`ifdef CONV_SCHED_WDOG_EN
  , parameter int WDOG_LIMIT    = 64
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       hold,
  input  logic                       abort,
  input  logic                       DPDone,
  output logic                       startSingleConv,
  output logic [addressBitWidth-1:0] row_base,
  output logic [addressBitWidth-1:0] col_base,
  output logic [addressBitWidth-1:0] win_index,
  output logic                       busy,
  output logic                       all_done,
  output logic                       wdog_err
);

  localparam int AW = addressBitWidth;

  localparam logic [AW:0]   C_IMG_ROWS = (AW+1)'(Img_rows);
  localparam logic [AW:0]   C_IMG_COLS = (AW+1)'(Img_cols);
  localparam logic [AW:0]   C_FROWS    = (AW+1)'(Filter_rows);
  localparam logic [AW:0]   C_FCOLS    = (AW+1)'(Filter_Cols);
  localparam logic [AW:0]   C_STRIDE_W = (AW+1)'(STRIDE);
  localparam logic [AW-1:0] C_STEP     = AW'(STRIDE);
  localparam logic [AW-1:0] C_ONE      = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_ADVANCE = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

  state_t r_state;
  logic   w_col_fits;
  logic   w_row_fits;
  logic   w_last;
  logic   w_wdog_trip;

  // One extra bit so the look-ahead sums cannot wrap near 2**AW.
  assign w_col_fits = ({1'b0, col_base} + C_STRIDE_W + C_FCOLS) <= C_IMG_COLS;
  assign w_row_fits = ({1'b0, row_base} + C_STRIDE_W + C_FROWS) <= C_IMG_ROWS;
  assign w_last     = !w_col_fits && !w_row_fits;

  // The pulse is the ISSUE state qualified by hold, so it lands in the cycle hold is low.
  assign startSingleConv = (r_state == S_ISSUE) && !hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      row_base  <= '0;
      col_base  <= '0;
      win_index <= '0;
      busy      <= 1'b0;
      all_done  <= 1'b0;
    end else begin
      all_done <= 1'b0;
      if (r_state != S_IDLE && abort) begin
        r_state <= S_IDLE;
        busy    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state   <= S_ISSUE;
              busy      <= 1'b1;
              row_base  <= '0;
              col_base  <= '0;
              win_index <= '0;
            end
          end
          S_ISSUE: begin
            if (!hold) r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (DPDone) begin
              if (w_last) begin
                r_state  <= S_FINISH;
                all_done <= 1'b1;
              end else begin
                r_state <= S_ADVANCE;
              end
            end else if (w_wdog_trip) begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end
          end
          S_ADVANCE: begin
            if (w_col_fits) begin
              col_base <= col_base + C_STEP;
            end else begin
              col_base <= '0;
              row_base <= row_base + C_STEP;
            end
            win_index <= win_index + C_ONE;
            r_state   <= S_ISSUE;
          end
          S_FINISH: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef CONV_SCHED_WDOG_EN
  localparam int CW = $clog2(WDOG_LIMIT + 1);

  logic [CW-1:0] r_wdog_cnt;

  // Counts WAIT cycles without DPDone; abort outranks a simultaneous trip.
  assign w_wdog_trip = (r_state == S_WAIT) && !DPDone && !abort &&
                       (r_wdog_cnt == CW'(WDOG_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wdog_cnt <= '0;
      wdog_err   <= 1'b0;
    end else begin
      if (r_state == S_ISSUE) begin
        r_wdog_cnt <= '0;
      end else if (r_state == S_WAIT && !DPDone && !w_wdog_trip) begin
        r_wdog_cnt <= r_wdog_cnt + CW'(1);
      end
      if (r_state == S_IDLE && start) begin
        wdog_err <= 1'b0;
      end else if (w_wdog_trip) begin
        wdog_err <= 1'b1;
      end
    end
  end
`else
  assign w_wdog_trip = 1'b0;
  assign wdog_err    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_window_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_window_scheduler
// Purpose  : Two scheduler instances (4x8/2x5/S1 and 6x9/2x5/S2) checked
//            every cycle against a window-arithmetic reference model.
// Revision : 1.0
// ============================================================================
module tb_conv_window_scheduler;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic reset;
  logic start_i[2], hold_i[2], abort_i[2], dp_i[2];
  logic ssc[2], bsy[2], adone[2], werr[2];
  logic [AW-1:0] rb[2], cb[2], wi[2];

  always #5 clk = ~clk;

  conv_window_scheduler #(
    .addressBitWidth(AW)
`ifdef CONV_SCHED_WDOG_EN
    , .WDOG_LIMIT(8)
`endif
  ) dut0 (
    .clk(clk), .reset(reset), .start(start_i[0]), .hold(hold_i[0]),
    .abort(abort_i[0]), .DPDone(dp_i[0]), .startSingleConv(ssc[0]),
    .row_base(rb[0]), .col_base(cb[0]), .win_index(wi[0]),
    .busy(bsy[0]), .all_done(adone[0]), .wdog_err(werr[0])
  );

  conv_window_scheduler #(
    .addressBitWidth(AW), .Img_rows(6), .Img_cols(9),
    .Filter_rows(2), .Filter_Cols(5), .STRIDE(2)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start_i[1]), .hold(hold_i[1]),
    .abort(abort_i[1]), .DPDone(dp_i[1]), .startSingleConv(ssc[1]),
    .row_base(rb[1]), .col_base(cb[1]), .win_index(wi[1]),
    .busy(bsy[1]), .all_done(adone[1]), .wdog_err(werr[1])
  );

  // Image geometry per instance and the window grid it implies.
  function automatic int f_step(input int d); return (d == 0) ? 1 : 2; endfunction
  function automatic int f_ncol(input int d);
    return (d == 0) ? (8 - 5) / 1 + 1 : (9 - 5) / 2 + 1;
  endfunction
  function automatic int f_nrow(input int d);
    return (d == 0) ? (4 - 2) / 1 + 1 : (6 - 2) / 2 + 1;
  endfunction
  function automatic int f_total(input int d); return f_ncol(d) * f_nrow(d); endfunction
`ifdef CONV_SCHED_WDOG_EN
  function automatic int f_wdl(input int d); return (d == 0) ? 8 : 64; endfunction
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: which window is current, and what is owed next.
  int m_k[2], m_wcnt[2];
  bit m_busy[2], m_pend[2], m_wait[2], m_adv[2], m_fin[2], m_done[2], m_err[2];
  bit exp_pulse[2];

  // Responder / stimulus helpers
  int  rcnt[2], lat[2];
  bit  resp_en[2], spur[2];
  logic last_ssc[2], last_bsy[2], last_adone[2], last_werr[2];
  logic [AW-1:0] last_rb[2], last_cb[2], last_wi[2];
  int  last_pulse_cyc[2], n_done[2];
  logic [3*AW-1:0] q0[$], q1[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_win(input string nm, input logic [3*AW-1:0] e, input int r, input int c, input int i);
    chk({nm, " row"}, 32'(e[3*AW-1:2*AW]), r);
    chk({nm, " col"}, 32'(e[2*AW-1:AW]), c);
    chk({nm, " idx"}, 32'(e[AW-1:0]), i);
  endtask

  task automatic check_cycle();
    for (int d = 0; d < 2; d++) begin
      int k, nc;
      k  = m_k[d];
      nc = f_ncol(d);
      exp_pulse[d] = m_pend[d] && !hold_i[d];
      chk($sformatf("d%0d startSingleConv", d), 32'(ssc[d]), 32'(exp_pulse[d]));
      chk($sformatf("d%0d row_base", d), 32'(rb[d]), (k / nc) * f_step(d));
      chk($sformatf("d%0d col_base", d), 32'(cb[d]), (k % nc) * f_step(d));
      chk($sformatf("d%0d win_index", d), 32'(wi[d]), k);
      chk($sformatf("d%0d busy", d), 32'(bsy[d]), 32'(m_busy[d]));
      chk($sformatf("d%0d all_done", d), 32'(adone[d]), 32'(m_done[d]));
      chk($sformatf("d%0d wdog_err", d), 32'(werr[d]), 32'(m_err[d]));
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_busy[d] = 0; m_pend[d] = 0; m_wait[d] = 0; m_adv[d] = 0;
        m_fin[d] = 0;  m_done[d] = 0; m_err[d] = 0;  m_k[d] = 0; m_wcnt[d] = 0;
      end else if (!m_busy[d]) begin
        m_done[d] = 0;
        if (start_i[d]) begin
          m_busy[d] = 1; m_k[d] = 0; m_pend[d] = 1; m_err[d] = 0;
        end
      end else if (abort_i[d]) begin
        m_busy[d] = 0; m_pend[d] = 0; m_wait[d] = 0; m_adv[d] = 0;
        m_fin[d] = 0;  m_done[d] = 0;
      end else if (m_fin[d]) begin
        m_fin[d] = 0; m_done[d] = 0; m_busy[d] = 0;
      end else if (m_adv[d]) begin
        m_adv[d] = 0; m_k[d]++; m_pend[d] = 1;
      end else if (m_pend[d]) begin
        if (exp_pulse[d]) begin
          m_pend[d] = 0; m_wait[d] = 1; m_wcnt[d] = 0;
        end
      end else if (m_wait[d]) begin
        if (dp_i[d]) begin
          m_wait[d] = 0;
          if (m_k[d] == f_total(d) - 1) begin
            m_fin[d] = 1; m_done[d] = 1;
          end else begin
            m_adv[d] = 1;
          end
        end
`ifdef CONV_SCHED_WDOG_EN
        else begin
          m_wcnt[d]++;
          if (m_wcnt[d] == f_wdl(d)) begin
            m_err[d] = 1; m_wait[d] = 0; m_busy[d] = 0;
          end
        end
`endif
      end
    end
  endtask

  // One clock: compare at negedge, advance model at posedge, drive DPDone after.
  task automatic tick();
    @(negedge clk);
    check_cycle();
    for (int d = 0; d < 2; d++) begin
      last_ssc[d] = ssc[d]; last_bsy[d] = bsy[d]; last_adone[d] = adone[d];
      last_werr[d] = werr[d]; last_rb[d] = rb[d]; last_cb[d] = cb[d]; last_wi[d] = wi[d];
      if (ssc[d] === 1'b1) begin
        last_pulse_cyc[d] = cyc;
        if (d == 0) q0.push_back({rb[0], cb[0], wi[0]});
        else        q1.push_back({rb[1], cb[1], wi[1]});
      end
      if (adone[d] === 1'b1) n_done[d]++;
    end
    @(posedge clk);
    model_edge();
    cyc++;
    for (int d = 0; d < 2; d++) if (last_ssc[d] === 1'b1) rcnt[d] = lat[d];
    #1;
    for (int d = 0; d < 2; d++) begin
      if (rcnt[d] > 0) begin
        rcnt[d]--;
        dp_i[d] = (rcnt[d] == 0) && resp_en[d];
      end else begin
        dp_i[d] = spur[d];
      end
    end
  endtask

  task automatic run_until_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bsy[0] === 1'b0 && bsy[1] === 1'b0) return;
    end
    chk("idle wait timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int b, nd;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_i[d] = 0; hold_i[d] = 0; abort_i[d] = 0; dp_i[d] = 0;
      rcnt[d] = 0; lat[d] = 3; resp_en[d] = 1; spur[d] = 0; n_done[d] = 0;
    end
    @(posedge clk); @(posedge clk); #1;
    tick();
    reset = 1'b0;
    tick();
    chk("reset row_base", 32'(last_rb[0]), 0);
    chk("reset busy", 32'(last_bsy[0]), 0);
    chk("reset startSingleConv", 32'(last_ssc[0]), 0);

    // T1 (default grid) and T2 (6x9, stride 2) run side by side
    q0.delete(); q1.delete(); n_done[0] = 0; n_done[1] = 0;
    start_i[0] = 1; start_i[1] = 1;
    tick();
    start_i[0] = 0; start_i[1] = 0;
    tick();
    chk("T1 pulse one cycle after start", 32'(last_ssc[0]), 1);
    run_until_idle(400);
    chk("T1 pulses", q0.size(), 12);
    chk_win("T1 w0", q0[0], 0, 0, 0);
    chk_win("T1 w3", q0[3], 0, 3, 3);
    chk_win("T1 w4", q0[4], 1, 0, 4);
    chk_win("T1 w11", q0[11], 2, 3, 11);
    chk("T1 all_done count", n_done[0], 1);
    chk("T2 pulses", q1.size(), 9);
    chk_win("T2 w2", q1[2], 0, 4, 2);
    chk_win("T2 w3", q1[3], 2, 0, 3);
    chk_win("T2 w8", q1[8], 4, 4, 8);
    chk("T2 all_done count", n_done[1], 1);

    // T3: hold for 5 cycles while window 2 is being issued
    start_i[0] = 1; tick(); start_i[0] = 0;
    for (b = 0; b < 100 && !(m_pend[0] && m_k[0] == 2); b++) tick();
    chk("T3 reached window 2", 32'(m_pend[0] && m_k[0] == 2), 1);
    hold_i[0] = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("T3 no pulse under hold", 32'(last_ssc[0]), 0);
      chk("T3 col held", 32'(last_cb[0]), 2);
    end
    hold_i[0] = 0;
    tick();
    chk("T3 pulse on hold release", 32'(last_ssc[0]), 1);
    chk("T3 col at pulse", 32'(last_cb[0]), 2);
    run_until_idle(200);

    // T4: abort while waiting on window 6, then restart from the origin
    nd = n_done[0];
    start_i[0] = 1; tick(); start_i[0] = 0;
    for (b = 0; b < 200 && !(m_wait[0] && m_k[0] == 6); b++) tick();
    chk("T4 reached window 6", 32'(m_wait[0] && m_k[0] == 6), 1);
    abort_i[0] = 1; rcnt[0] = 0;
    tick();
    abort_i[0] = 0;
    tick();
    chk("T4 busy after abort", 32'(last_bsy[0]), 0);
    repeat (4) tick();
    chk("T4 no all_done", n_done[0], nd);
    q0.delete();
    start_i[0] = 1; tick(); start_i[0] = 0;
    tick();
    chk("T4 restart pulse", 32'(last_ssc[0]), 1);
    chk("T4 restart index", 32'(last_wi[0]), 0);
    chk("T4 restart col", 32'(last_cb[0]), 0);
    run_until_idle(200);
    chk("T4 restart pass pulses", q0.size(), 12);

    // T5: reset mid-WAIT, spurious DPDone while idle, start while busy
    start_i[0] = 1; tick(); start_i[0] = 0;
    for (b = 0; b < 200 && !(m_wait[0] && m_k[0] == 3); b++) tick();
    reset = 1; rcnt[0] = 0; rcnt[1] = 0;
    tick();
    reset = 0;
    tick();
    chk("T5 row after reset", 32'(last_rb[0]), 0);
    chk("T5 col after reset", 32'(last_cb[0]), 0);
    chk("T5 idx after reset", 32'(last_wi[0]), 0);
    chk("T5 busy after reset", 32'(last_bsy[0]), 0);
    dp_i[0] = 1;
    tick();
    tick();
    chk("T5 spurious DPDone ignored", 32'(last_bsy[0]), 0);
    q0.delete(); nd = n_done[0];
    start_i[0] = 1; tick(); start_i[0] = 0;
    repeat (6) tick();
    start_i[0] = 1; repeat (3) tick(); start_i[0] = 0;
    run_until_idle(200);
    chk("T5 pass pulses", q0.size(), 12);
    chk("T5 all_done count", n_done[0] - nd, 1);

`ifdef CONV_SCHED_WDOG_EN
    // T6: DPDone withheld until the watchdog fires
    resp_en[0] = 0; nd = n_done[0];
    start_i[0] = 1; tick(); start_i[0] = 0;
    for (b = 0; b < 40 && last_werr[0] !== 1'b1; b++) tick();
    chk("T6 wdog_err set", 32'(last_werr[0]), 1);
    chk("T6 pulse to error cycles", cyc - 1 - last_pulse_cyc[0], 9);
    chk("T6 busy dropped", 32'(last_bsy[0]), 0);
    chk("T6 no all_done", n_done[0], nd);
    resp_en[0] = 1;
    start_i[0] = 1; tick(); start_i[0] = 0;
    tick();
    chk("T6 wdog_err cleared by start", 32'(last_werr[0]), 0);
    run_until_idle(200);
`endif

    // Randomised phase against the model
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 799) == 0);
      for (int d = 0; d < 2; d++) begin
        start_i[d] = ($urandom_range(0, 7) == 0);
        hold_i[d]  = ($urandom_range(0, 3) == 0);
        abort_i[d] = ($urandom_range(0, 96) == 0);
        spur[d]    = ($urandom_range(0, 15) == 0);
        lat[d]     = $urandom_range(1, 5);
      end
      tick();
    end
    reset = 0;
    for (int d = 0; d < 2; d++) begin
      start_i[d] = 0; hold_i[d] = 0; abort_i[d] = 0; spur[d] = 0;
    end
    run_until_idle(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
